// File: rtl/rom_map_pkg.sv
// -----------------------------------------------------------------------------
// rom_map_pkg: Time Pilot '84 ROM bank map shared by the SD loader and uploader.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package rom_map_pkg;

   localparam logic [24:0] EPROM_BYTES = 25'h2000;
   localparam logic [24:0] PROM_BYTES  = 25'h100;
   localparam logic [24:0] PROM_BASE   = 25'h18000;
   localparam logic [24:0] ROM_LAST    = 25'h184FF;
   localparam int          NUM_BANKS   = 17;

   typedef logic [4:0] bank_idx_t;

   typedef enum logic [1:0] {
      UPL_IDLE    = 2'd0,
      UPL_ISSUE   = 2'd1,
      UPL_WAIT    = 2'd2,
      UPL_CAPTURE = 2'd3
   } upl_state_t;

   typedef struct packed {
      bank_idx_t   bank;
      logic [12:0] offset;
      logic        in_range;
   } rom_loc_t;

   // Twelve 8 KiB EPROMs are followed by five 256 B PROMs starting at bank 12.
   function automatic rom_loc_t rom_decode(input logic [24:0] addr);
      rom_loc_t r;
      r.in_range = (addr <= ROM_LAST);
      if (addr < PROM_BASE) begin
         r.bank   = bank_idx_t'(addr / EPROM_BYTES);
         r.offset = 13'(addr % EPROM_BYTES);
      end else begin
         r.bank   = 5'd12 + bank_idx_t'((addr - PROM_BASE) / PROM_BYTES);
         r.offset = 13'(addr % PROM_BYTES);
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rom_bank_decode.sv
// -----------------------------------------------------------------------------
// rom_bank_decode: byte address to bank index, one-hot select and bank offset.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rom_bank_decode
   import rom_map_pkg::*;
(
   input  logic [24:0]          addr_i,
   output bank_idx_t            bank_o,
   output logic [NUM_BANKS-1:0] onehot_o,
   output logic [12:0]          offset_o,
   output logic                 in_range_o
);

   rom_loc_t w_loc;

   always_comb begin
      w_loc      = rom_decode(addr_i);
      bank_o     = w_loc.bank;
      offset_o   = w_loc.offset;
      in_range_o = w_loc.in_range;
      onehot_o   = '0;
      if (w_loc.in_range) begin
         onehot_o = {{(NUM_BANKS-1){1'b0}}, 1'b1} << w_loc.bank;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rom_uploader.sv
// -----------------------------------------------------------------------------
// rom_uploader: services ioctl upload reads from the ROM banks, with checksum.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rom_uploader
   import rom_map_pkg::*;
#(
   parameter int          RAM_LATENCY = 1,
   parameter logic [24:0] LAST_ADDR   = 25'h184FF
) (
   input  logic                      CLK,
   input  logic                      RESET_N,
   input  logic                      UPLOAD,
   input  logic                      RD,
   input  logic [24:0]               ADDR_UL,
   output logic [7:0]                DIN,
   output logic [12:0]               RAM_ADDR,
   output logic [NUM_BANKS-1:0]      BANK_SEL,
   input  logic [NUM_BANKS-1:0][7:0] BANK_Q,
   output logic                      BUSY,
   output logic                      ACK,
   output logic                      DONE,
   output logic [7:0]                CHECKSUM,
   output logic                      ERR
);

   bank_idx_t             w_dec_bank;
   logic [NUM_BANKS-1:0]  w_dec_onehot;
   logic [12:0]           w_dec_offset;
   logic                  w_dec_in_range;
   logic                  w_accept_ok;
   logic                  w_upload_rise;

   upl_state_t            state_q;
   logic [1:0]            cnt_q;
   bank_idx_t             bank_q;
   logic                  last_q;
   logic                  upload_q;
   logic [7:0]            din_q;
   logic [12:0]           ram_addr_q;
   logic [NUM_BANKS-1:0]  bank_sel_q;
   logic                  busy_q;
   logic                  ack_q;
   logic                  done_q;
   logic [7:0]            csum_q;
   logic                  err_q;

   rom_bank_decode u_decode (
      .addr_i     (ADDR_UL),
      .bank_o     (w_dec_bank),
      .onehot_o   (w_dec_onehot),
      .offset_o   (w_dec_offset),
      .in_range_o (w_dec_in_range)
   );

   assign w_accept_ok   = w_dec_in_range && (ADDR_UL <= LAST_ADDR);
   assign w_upload_rise = UPLOAD && !upload_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= UPL_IDLE;
         cnt_q      <= '0;
         bank_q     <= '0;
         last_q     <= 1'b0;
         upload_q   <= 1'b0;
         din_q      <= '0;
         ram_addr_q <= '0;
         bank_sel_q <= '0;
         busy_q     <= 1'b0;
         ack_q      <= 1'b0;
         done_q     <= 1'b0;
         csum_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         upload_q <= UPLOAD;
         ack_q    <= 1'b0;
         done_q   <= 1'b0;
         // Session clear is applied first so a same-cycle RD can still flag ERR.
         if (w_upload_rise) begin
            csum_q <= '0;
            err_q  <= 1'b0;
         end
         if (!UPLOAD) begin
            state_q    <= UPL_IDLE;
            busy_q     <= 1'b0;
            bank_sel_q <= '0;
         end else begin
            case (state_q)
               UPL_IDLE: begin
                  if (RD) begin
                     if (w_accept_ok) begin
                        ram_addr_q <= w_dec_offset;
                        bank_sel_q <= w_dec_onehot;
                        bank_q     <= w_dec_bank;
                        last_q     <= (ADDR_UL == LAST_ADDR);
                        busy_q     <= 1'b1;
                        state_q    <= UPL_ISSUE;
                     end else begin
                        din_q <= 8'hFF;
                        ack_q <= 1'b1;
                        err_q <= 1'b1;
                     end
                  end
               end
               UPL_ISSUE: begin
                  cnt_q   <= 2'(RAM_LATENCY - 1);
                  state_q <= (RAM_LATENCY == 1) ? UPL_CAPTURE : UPL_WAIT;
                  if (RD) err_q <= 1'b1;
               end
               UPL_WAIT: begin
                  cnt_q <= cnt_q - 2'd1;
                  if (cnt_q == 2'd1) state_q <= UPL_CAPTURE;
                  if (RD) err_q <= 1'b1;
               end
               UPL_CAPTURE: begin
                  din_q      <= BANK_Q[bank_q];
                  csum_q     <= csum_q + BANK_Q[bank_q];
                  ack_q      <= 1'b1;
                  done_q     <= last_q;
                  busy_q     <= 1'b0;
                  bank_sel_q <= '0;
                  state_q    <= UPL_IDLE;
                  if (RD) err_q <= 1'b1;
               end
               default: state_q <= UPL_IDLE;
            endcase
         end
      end
   end

   assign DIN      = din_q;
   assign RAM_ADDR = ram_addr_q;
   assign BANK_SEL = bank_sel_q;
   assign BUSY     = busy_q;
   assign ACK      = ack_q;
   assign DONE     = done_q;
   assign CHECKSUM = csum_q;
   assign ERR      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_rom_uploader.sv
// -----------------------------------------------------------------------------
// tb_rom_uploader: directed + random reads against a bank-map reference model.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_rom_uploader;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              upload;
   logic              rd;
   logic [24:0]       addr;
   logic [16:0][7:0]  bq1, bq3;
   logic [7:0]        din, din3, csum, csum3;
   logic [12:0]       ram_addr, ram_addr3, a3_1, a3_2;
   logic [16:0]       bank_sel, bank_sel3;
   logic              busy, ack, done, err, busy3, ack3, done3, err3;

   logic [7:0]        mem [0:16][0:8191];
   logic [7:0]        exp_csum;
   logic [7:0]        exp_din;
   int                n_cmp = 0;
   int                n_err = 0;

   always #5 clk = ~clk;

   rom_uploader #(.RAM_LATENCY(1)) dut (
      .CLK(clk), .RESET_N(rst_n), .UPLOAD(upload), .RD(rd), .ADDR_UL(addr),
      .DIN(din), .RAM_ADDR(ram_addr), .BANK_SEL(bank_sel), .BANK_Q(bq1),
      .BUSY(busy), .ACK(ack), .DONE(done), .CHECKSUM(csum), .ERR(err)
   );

   rom_uploader #(.RAM_LATENCY(3)) dut3 (
      .CLK(clk), .RESET_N(rst_n), .UPLOAD(upload), .RD(rd), .ADDR_UL(addr),
      .DIN(din3), .RAM_ADDR(ram_addr3), .BANK_SEL(bank_sel3), .BANK_Q(bq3),
      .BUSY(busy3), .ACK(ack3), .DONE(done3), .CHECKSUM(csum3), .ERR(err3)
   );

   // Bank RAMs: shared address, PROMs see only the low 8 address bits.
   always @(posedge clk) begin
      for (int b = 0; b < 17; b++) begin
         bq1[b] <= mem[b][(b >= 12) ? {5'd0, ram_addr[7:0]} : ram_addr];
         bq3[b] <= mem[b][(b >= 12) ? {5'd0, a3_2[7:0]} : a3_2];
      end
      a3_1 <= ram_addr3;
      a3_2 <= a3_1;
   end

   function automatic int ref_bank(input int a);
      return (a < 'h18000) ? a / 8192 : 12 + (a - 'h18000) / 256;
   endfunction

   function automatic int ref_off(input int a);
      return (a < 'h18000) ? a % 8192 : a % 256;
   endfunction

   function automatic logic [7:0] ref_byte(input int a);
      return mem[ref_bank(a)][ref_off(a)];
   endfunction

   function automatic logic [16:0] ref_sel(input int a);
      logic [16:0] s;
      s = 17'd1 << ref_bank(a);
      return s;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One read on the latency-1 DUT; returns in the ACK cycle so a follow-up RD is back-to-back.
   task automatic rd_check(input int a);
      logic [7:0] b;
      addr = 25'(a);
      rd   = 1'b1;
      tick;
      rd   = 1'b0;
      if (a > 'h184FF) begin
         exp_din = 8'hFF;
         chk("oor_ack",  32'(ack),  32'd1);
         chk("oor_din",  32'(din),  32'hFF);
         chk("oor_err",  32'(err),  32'd1);
         chk("oor_busy", 32'(busy), 32'd0);
         chk("oor_csum", 32'(csum), 32'(exp_csum));
      end else begin
         chk("sel",   32'(bank_sel), 32'(ref_sel(a)));
         chk("raddr", 32'(ram_addr), 32'(ref_off(a)));
         chk("busy1", 32'(busy), 32'd1);
         chk("ack1",  32'(ack),  32'd0);
         tick;
         chk("busy2", 32'(busy), 32'd1);
         chk("ack2",  32'(ack),  32'd0);
         tick;
         b        = ref_byte(a);
         exp_csum = exp_csum + b;
         exp_din  = b;
         chk("ack",      32'(ack),      32'd1);
         chk("din",      32'(din),      32'(b));
         chk("csum",     32'(csum),     32'(exp_csum));
         chk("done",     32'(done),     32'(a == 'h184FF));
         chk("busy3",    32'(busy),     32'd0);
         chk("sel_idle", 32'(bank_sel), 32'd0);
      end
   endtask

   initial begin
      int a;
      rst_n    = 1'b0;
      upload   = 1'b0;
      rd       = 1'b0;
      addr     = '0;
      exp_csum = '0;
      exp_din  = '0;
      for (int b = 0; b < 17; b++) begin
         for (int i = 0; i < 8192; i++) begin
            mem[b][i] = (b >= 12) ? 8'($urandom_range(0, 15)) : 8'($urandom);
         end
      end
      mem[0][0]  = 8'h5A;
      mem[15][5] = 8'h09;
      tick;
      tick;

      chk("rst_din",  32'(din),      32'd0);
      chk("rst_ra",   32'(ram_addr), 32'd0);
      chk("rst_sel",  32'(bank_sel), 32'd0);
      chk("rst_busy", 32'(busy),     32'd0);
      chk("rst_ack",  32'(ack),      32'd0);
      chk("rst_done", 32'(done),     32'd0);
      chk("rst_csum", 32'(csum),     32'd0);
      chk("rst_err",  32'(err),      32'd0);
      rst_n = 1'b1;
      tick;

      upload = 1'b1;
      tick;
      rd_check('h00000);
      rd_check('h18305);
      rd_check('h184FF);
      for (int i = 'h13FFE; i <= 'h14001; i++) rd_check(i);
      rd_check('h18500);

      for (int i = 0; i < 16; i++) begin
         a = int'($urandom_range(0, 'h18600));
         rd_check(a);
      end

      // UPLOAD falls in the capture cycle: read is abandoned.
      addr = 25'h02345;
      rd   = 1'b1;
      tick;
      rd   = 1'b0;
      tick;
      upload = 1'b0;
      tick;
      chk("abort_ack",  32'(ack),      32'd0);
      chk("abort_busy", 32'(busy),     32'd0);
      chk("abort_sel",  32'(bank_sel), 32'd0);
      chk("abort_din",  32'(din),      32'(exp_din));
      chk("abort_csum", 32'(csum),     32'(exp_csum));
      tick;
      chk("abort_ack2", 32'(ack),      32'd0);
      upload = 1'b1;
      tick;
      exp_csum = '0;
      chk("rise_csum", 32'(csum), 32'd0);
      chk("rise_err",  32'(err),  32'd0);

      // RD while busy is dropped but flagged.
      addr = 25'h00100;
      rd   = 1'b1;
      tick;
      chk("busyrd_err0", 32'(err), 32'd0);
      addr = 25'h18000;
      tick;
      rd   = 1'b0;
      chk("busyrd_err1", 32'(err), 32'd1);
      tick;
      exp_csum = exp_csum + ref_byte('h100);
      chk("busyrd_ack",  32'(ack),  32'd1);
      chk("busyrd_din",  32'(din),  32'(ref_byte('h100)));
      chk("busyrd_csum", 32'(csum), 32'(exp_csum));

      // Out-of-range RD on the same cycle as the UPLOAD rising edge.
      upload = 1'b0;
      tick;
      upload   = 1'b1;
      exp_csum = '0;
      rd_check('h18500);

      // Latency-3 instance: asynchronous reset mid-read, then a full read.
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
      addr = 25'h04321;
      rd   = 1'b1;
      tick;
      rd   = 1'b0;
      tick;
      chk("l3_busy_pre", 32'(busy3),     32'd1);
      chk("l3_sel_pre",  32'(bank_sel3), 32'(ref_sel('h04321)));
      rst_n = 1'b0;
      #1;
      chk("l3_rst_din",  32'(din3),      32'd0);
      chk("l3_rst_ra",   32'(ram_addr3), 32'd0);
      chk("l3_rst_sel",  32'(bank_sel3), 32'd0);
      chk("l3_rst_busy", 32'(busy3),     32'd0);
      chk("l3_rst_ack",  32'(ack3),      32'd0);
      chk("l3_rst_done", 32'(done3),     32'd0);
      chk("l3_rst_csum", 32'(csum3),     32'd0);
      chk("l3_rst_err",  32'(err3),      32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick;
      addr = 25'h18123;
      rd   = 1'b1;
      tick;
      rd   = 1'b0;
      chk("l3_busy1", 32'(busy3),     32'd1);
      chk("l3_ra",    32'(ram_addr3), 32'h023);
      tick;
      tick;
      tick;
      chk("l3_ack4",  32'(ack3),  32'd0);
      chk("l3_busy4", 32'(busy3), 32'd1);
      tick;
      chk("l3_ack5",  32'(ack3),  32'd1);
      chk("l3_din5",  32'(din3),  32'(ref_byte('h18123)));
      chk("l3_csum5", 32'(csum3), 32'(ref_byte('h18123)));
      chk("l3_busy5", 32'(busy3), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
